// File: rtl/apb_req_initiator.sv
// Core-side APB3 initiator: converts a req/gnt/rvalid transfer into one
// SETUP/ACCESS sequence, with PSLVERR reporting and an ACCESS-phase timeout.
module apb_req_initiator #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          timeout_hit;
  logic          unused_addr_lsb;

  // Byte lanes below word granularity are never driven onto PADDR.
  assign unused_addr_lsb = ^addr_i[1:0];

  // PREADY on the last permitted cycle takes priority over the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !pready_i;

  // Next-state and APB/core handshake outputs.
  always_comb begin
    state_d   = state_q;
    gnt_o     = 1'b0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    rvalid_o  = 1'b0;
    busy_o    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        gnt_o = req_i;
        if (req_i) state_d = S_SETUP;
      end
      S_SETUP: begin
        psel_o  = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        rvalid_o = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Wait-state counter: cleared on grant, saturating while PREADY is low in ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE && req_i) begin
      cnt_q <= '0;
    end else if (state_q == S_ACCESS && !pready_i && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Request capture at grant; held stable for the whole APB transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_o  <= '0;
      pwdata_o <= '0;
      pwrite_o <= 1'b0;
    end else if (state_q == S_IDLE && req_i) begin
      paddr_o  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
      pwdata_o <= wdata_i;
      pwrite_o <= we_i;
    end
  end

  // Response capture on entry to RESP; holds between completions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else if (state_q == S_ACCESS && pready_i) begin
      rdata_o <= pwrite_o ? '0 : prdata_i;
      err_o   <= pslverr_i;
    end else if (state_q == S_ACCESS && timeout_hit) begin
      rdata_o <= '0;
      err_o   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_req_initiator.sv
// Scoreboard bench for apb_req_initiator with a directed APB slave model.
module tb_apb_req_initiator;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0] rdata_o, paddr_o, pwdata_o;
  logic        pwrite_o, psel_o, penable_o;
  logic [31:0] prdata_i;
  logic        pready_i, pslverr_i;

  apb_req_initiator #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .psel_o(psel_o),
    .penable_o(penable_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  resp_t mon_e;
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    acc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rvalid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rvalid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_rdata", rdata_o, mon_e.rdata);
        chk("sb_err", err_o, mon_e.err);
      end
    end
  end

  // Slave model, called once per negedge: PREADY after w ACCESS cycles unless hung.
  // Outside ACCESS (and while not ready) the APB inputs carry junk that must be ignored.
  task automatic slave_step(input int w, input bit hang, input logic [31:0] rd, input bit se);
    if (psel_o && penable_o) begin
      if (!hang && acc >= w) begin
        pready_i  = 1'b1;
        prdata_i  = rd;
        pslverr_i = se;
      end else begin
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom_range(0, 1));
      end
      acc++;
    end else begin
      pready_i  = 1'($urandom_range(0, 1));
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom_range(0, 1));
      acc       = 0;
    end
  endtask

  task automatic xfer(input string nm, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int w, input bit hang,
                      input logic [31:0] rd, input bit se, input logic [31:0] exp_paddr,
                      input logic [31:0] exp_rdata, input bit exp_err, input int exp_acc);
    int g, n_acc, n_setup;
    bit done;
    resp_t e;
    @(negedge clk_i);
    slave_step(w, hang, rd, se);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    #1;
    chk({nm, "_gnt"}, gnt_o, 1);
    g = cyc;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = ~we; addr_i = $urandom; wdata_i = $urandom;
    n_acc = 0; n_setup = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (psel_o) begin
        chk({nm, "_paddr"}, paddr_o, exp_paddr);
        chk({nm, "_pwrite"}, pwrite_o, we);
        chk({nm, "_pwdata"}, pwdata_o, wdata);
        if (penable_o) n_acc++;
        else           n_setup++;
      end
      if (rvalid_o) begin
        done = 1;
        chk({nm, "_latency"}, cyc - g, exp_acc + 2);
        chk({nm, "_psel_in_resp"}, {psel_o, penable_o}, 0);
      end
      slave_step(w, hang, rd, se);
    end
    chk({nm, "_completed"}, done, 1);
    chk({nm, "_access_cycles"}, n_acc, exp_acc);
    chk({nm, "_setup_cycles"}, n_setup, 1);
    @(negedge clk_i);
    slave_step(w, hang, rd, se);
    chk({nm, "_rvalid_pulse"}, rvalid_o, 0);
    chk({nm, "_rdata_hold"}, rdata_o, exp_rdata);
    chk({nm, "_err_hold"}, err_o, exp_err);
    chk({nm, "_busy_idle"}, busy_o, 0);
  endtask

  logic [31:0] b_addr [3] = '{32'h1A10_5000, 32'h1A10_5006, 32'h1A10_500B};
  logic [31:0] b_paddr[3] = '{32'h1A10_5000, 32'h1A10_5004, 32'h1A10_5008};
  logic [31:0] b_rd   [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  initial begin
    resp_t e;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    #2;
    chk("rst_outputs",
        {gnt_o, rvalid_o, err_o, busy_o, pwrite_o, psel_o, penable_o}, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    xfer("rd_zero_wait", 1'b0, 32'h1A10_0004, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0,
         32'h1A10_0004, 32'hCAFE_F00D, 1'b0, 1);
    xfer("wr_3_waits", 1'b1, 32'h1A10_1000, 32'h1234_5678, 3, 1'b0, 32'hDEAD_BEEF, 1'b0,
         32'h1A10_1000, 32'h0, 1'b0, 4);
    xfer("rd_pslverr", 1'b0, 32'h1A10_2008, 32'h0, 0, 1'b0, 32'h0BAD_0BAD, 1'b1,
         32'h1A10_2008, 32'h0BAD_0BAD, 1'b1, 1);
    xfer("rd_timeout", 1'b0, 32'h1A10_300C, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0,
         32'h1A10_300C, 32'h0, 1'b1, 4);
    xfer("rd_ready_last", 1'b0, 32'h1A10_3010, 32'h0, 3, 1'b0, 32'h55AA_33CC, 1'b0,
         32'h1A10_3010, 32'h55AA_33CC, 1'b0, 4);
    xfer("wr_unaligned", 1'b1, 32'h1A10_0007, 32'hA5A5_5A5A, 1, 1'b0, 32'h7777_7777, 1'b0,
         32'h1A10_0004, 32'h0, 1'b0, 2);

    // Back-to-back: req_i held high; grants every 4th cycle, none in RESP.
    @(negedge clk_i);
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk_i);
      slave_step(0, 1'b0, b_rd[c/4], 1'b0);
      req_i = (c != 11); we_i = 1'b0; addr_i = b_addr[c/4];
      #1;
      chk("b2b_gnt", gnt_o, (c % 4 == 0));
      chk("b2b_psel", psel_o, (c % 4 == 1 || c % 4 == 2));
      chk("b2b_rvalid", rvalid_o, (c % 4 == 3));
      if (c % 4 == 0) begin
        e.rdata = b_rd[c/4];
        e.err   = 1'b0;
        sb_q.push_back(e);
      end
      if (c % 4 == 1) chk("b2b_paddr", paddr_o, b_paddr[c/4]);
    end
    req_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      slave_step(0, 1'b0, 32'h0, 1'b0);
      chk("b2b_no_extra_psel", psel_o, 0);
    end

    // Reset while the slave holds PREADY low: transfer dropped immediately.
    @(negedge clk_i);
    slave_step(0, 1'b1, 32'h0, 1'b0);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_4000;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      slave_step(0, 1'b1, 32'h0, 1'b0);
    end
    chk("rst_mid_in_access", {psel_o, penable_o}, 2'b11);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_outputs", {psel_o, penable_o, rvalid_o, busy_o}, 0);
    chk("rst_mid_rdata", rdata_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    xfer("rd_after_rst", 1'b0, 32'h1A10_4004, 32'h0, 0, 1'b0, 32'h600D_D00D, 1'b0,
         32'h1A10_4004, 32'h600D_D00D, 1'b0, 1);

    repeat (2) @(negedge clk_i);
    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
